// File: rtl/lsu_axi_pkg.sv
// Shared encodings for the LSU bus master: access sizes, AXI response codes,
// FSM state codes and a byte-count helper.
package lsu_axi_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_WRESP = 3'd2;
  localparam logic [2:0] ST_RADDR = 3'd3;
  localparam logic [2:0] ST_RDATA = 3'd4;
  localparam logic [2:0] ST_RESP  = 3'd5;

  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store data/strobe placement and load extract + extend.
module lsu_lane_align
  import lsu_axi_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int OFFW       = $clog2(DATA_WIDTH/8)
) (
  input  logic [OFFW-1:0]         off,
  input  logic [1:0]              size,
  input  logic                    sgn,
  input  logic [DATA_WIDTH-1:0]   st_data,
  input  logic [DATA_WIDTH-1:0]   ld_raw,
  output logic [DATA_WIDTH-1:0]   st_lane,
  output logic [DATA_WIDTH/8-1:0] st_strb,
  output logic [DATA_WIDTH-1:0]   ld_data
);

  localparam int NB = DATA_WIDTH/8;

  logic [3:0]            nbytes;
  logic [6:0]            nbits;
  logic [NB-1:0]         strb;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  sbit;

  always_comb begin
    nbytes  = size_bytes(size);
    nbits   = {nbytes, 3'b000};
    // Shifting all-ones by >= width yields zero, so oversize accesses saturate to full width.
    strb    = ~({NB{1'b1}} << nbytes);
    mask    = ~({DATA_WIDTH{1'b1}} << nbits);
    st_lane = st_data << {off, 3'b000};
    st_strb = strb << off;
    shifted = ld_raw >> {off, 3'b000};
    case (size)
      SZ_B:    sbit = shifted[7];
      SZ_H:    sbit = shifted[15];
      SZ_W:    sbit = shifted[31];
      default: sbit = shifted[DATA_WIDTH-1];
    endcase
    ld_data = (shifted & mask) | ({DATA_WIDTH{sgn & sbit}} & ~mask);
  end

endmodule

// File: rtl/lsu_axi_master.sv
// Single-outstanding LSU bus master: pipeline valid/ready request in,
// AXI4-Lite-style transaction out, aligned/extended completion back.
module lsu_axi_master
  import lsu_axi_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_WIDTH   = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [RD_WIDTH-1:0]     req_rd,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [RD_WIDTH-1:0]     rsp_rd,
  output logic                    rsp_we,
  output logic                    rsp_misalign,
  output logic                    rsp_buserr,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [1:0]              bresp,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  output logic                    busy
);

  localparam int OFFW = $clog2(DATA_WIDTH/8);

  logic [2:0]            state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  sgn_q, sgn_d;
  logic [DATA_WIDTH-1:0] st_q, st_d;
  logic [RD_WIDTH-1:0]   rd_q, rd_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                  bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [RD_WIDTH-1:0]   rsp_rd_q, rsp_rd_d;
  logic                  rsp_mis_q, rsp_mis_d, rsp_err_q, rsp_err_d;

  logic                    accept, mis;
  logic [DATA_WIDTH-1:0]   st_lane, ld_data;
  logic [DATA_WIDTH/8-1:0] st_strb;

  lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .off     (addr_q[OFFW-1:0]),
    .size    (size_q),
    .sgn     (sgn_q),
    .st_data (st_q),
    .ld_raw  (rdata),
    .st_lane (st_lane),
    .st_strb (st_strb),
    .ld_data (ld_data)
  );

  always_comb begin
    case (req_size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = req_addr[0];
      SZ_W:    mis = |req_addr[1:0];
      default: mis = (DATA_WIDTH == 32) || (|req_addr[2:0]);
    endcase
  end

  assign accept = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    st_d        = st_q;
    rd_d        = rd_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_rd_d    = rsp_rd_q;
    rsp_mis_d   = rsp_mis_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        we_d   = req_we;
        addr_d = req_addr;
        size_d = req_size;
        sgn_d  = req_signed;
        st_d   = req_wdata;
        rd_d   = req_rd;
        if (mis) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_mis_d   = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          rsp_rd_d    = req_we ? '0 : req_rd;
        end else if (req_we) begin
          state_d   = ST_WRITE;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          state_d   = ST_RADDR;
          arvalid_d = 1'b1;
        end
      end
      ST_WRITE: begin
        // AW and W complete independently; move on once both have landed.
        if (awvalid_q && awready) begin
          aw_done_d = 1'b1;
          awvalid_d = 1'b0;
        end
        if (wvalid_q && wready) begin
          w_done_d = 1'b1;
          wvalid_d = 1'b0;
        end
        if (aw_done_d && w_done_d) begin
          state_d  = ST_WRESP;
          bready_d = 1'b1;
        end
      end
      ST_WRESP: if (bvalid) begin
        state_d     = ST_RESP;
        bready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = (bresp != RESP_OKAY);
        rsp_mis_d   = 1'b0;
        rsp_rdata_d = '0;
        rsp_rd_d    = '0;
      end
      ST_RADDR: if (arready) begin
        state_d   = ST_RDATA;
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
      end
      ST_RDATA: if (rvalid) begin
        state_d     = ST_RESP;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = (rresp != RESP_OKAY);
        rsp_mis_d   = 1'b0;
        rsp_rdata_d = (rresp != RESP_OKAY) ? '0 : ld_data;
        rsp_rd_d    = rd_q;
      end
      ST_RESP: if (rsp_ready) begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_rd_d    = '0;
        rsp_mis_d   = 1'b0;
        rsp_err_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      size_q      <= SZ_B;
      sgn_q       <= 1'b0;
      st_q        <= '0;
      rd_q        <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_rd_q    <= '0;
      rsp_mis_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      st_q        <= st_d;
      rd_q        <= rd_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_mis_q   <= rsp_mis_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign busy         = ~req_ready;
  assign awvalid      = awvalid_q;
  assign wvalid       = wvalid_q;
  assign bready       = bready_q;
  assign arvalid      = arvalid_q;
  assign rready       = rready_q;
  assign awaddr       = addr_q;
  assign araddr       = addr_q;
  assign wdata        = st_lane;
  // Strobe is only meaningful alongside wvalid; keep it quiet otherwise.
  assign wstrb        = wvalid_q ? st_strb : '0;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_rd       = rsp_rd_q;
  assign rsp_misalign = rsp_mis_q;
  assign rsp_buserr   = rsp_err_q;
  assign rsp_we       = rsp_valid_q & ~we_q & ~rsp_mis_q & ~rsp_err_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Randomised + directed bench for lsu_axi_master with a reactive AXI slave
// and an arithmetic reference model of the expected bus beats and completions.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_ready, req_we = 0, req_signed = 0;
  logic [31:0] req_addr = 0;
  logic [1:0]  req_size = 0;
  logic [63:0] req_wdata = 0;
  logic [4:0]  req_rd = 0;
  logic        rsp_valid, rsp_ready = 0, rsp_we, rsp_misalign, rsp_buserr;
  logic [63:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
  logic [31:0] awaddr, araddr;
  logic [63:0] wdata, rdata = 0;
  logic [7:0]  wstrb;
  logic [1:0]  bresp = 0, rresp = 0;
  logic        arvalid, arready = 0, rvalid = 0, rready, busy;

  lsu_axi_master #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .RD_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd),
    .rsp_we(rsp_we), .rsp_misalign(rsp_misalign), .rsp_buserr(rsp_buserr),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .busy(busy)
  );

  // 32-bit instance, used only to check that a doubleword access traps.
  logic        z1 = 0;
  logic [1:0]  z2 = 0;
  logic [4:0]  z5 = 0;
  logic [31:0] z32 = 0;
  logic        rv32 = 0, rr32 = 0;
  logic [31:0] ra32 = 0;
  logic [1:0]  rs32 = 0;
  logic        req_ready32, rsp_valid32, rsp_we32, rsp_mis32, rsp_err32;
  logic [31:0] rsp_rdata32, awaddr32, araddr32, wdata32;
  logic [4:0]  rsp_rd32;
  logic [3:0]  wstrb32;
  logic        awvalid32, wvalid32, bready32, arvalid32, rready32, busy32;

  lsu_axi_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RD_WIDTH(5)) dut32 (
    .clk(clk), .rst(rst),
    .req_valid(rv32), .req_ready(req_ready32), .req_we(z1), .req_addr(ra32),
    .req_size(rs32), .req_signed(z1), .req_wdata(z32), .req_rd(z5),
    .rsp_valid(rsp_valid32), .rsp_ready(rr32), .rsp_rdata(rsp_rdata32), .rsp_rd(rsp_rd32),
    .rsp_we(rsp_we32), .rsp_misalign(rsp_mis32), .rsp_buserr(rsp_err32),
    .awvalid(awvalid32), .awready(z1), .awaddr(awaddr32),
    .wvalid(wvalid32), .wready(z1), .wdata(wdata32), .wstrb(wstrb32),
    .bvalid(z1), .bready(bready32), .bresp(z2),
    .arvalid(arvalid32), .arready(z1), .araddr(araddr32),
    .rvalid(z1), .rready(rready32), .rdata(z32), .rresp(z2),
    .busy(busy32)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave behaviour for the next transaction.
  int          aw_wait, w_wait, b_wait, ar_wait, r_wait, hold, abort_cyc;
  logic [1:0]  bresp_v, rresp_v;
  logic [63:0] rdata_v, last_rdata;

  task automatic slave_cfg(input int aw, w, b, ar, r, h, input logic [1:0] br, rr,
                           input logic [63:0] rd, input int ab);
    aw_wait = aw; w_wait = w; b_wait = b; ar_wait = ar; r_wait = r; hold = h;
    bresp_v = br; rresp_v = rr; rdata_v = rd; abort_cyc = ab;
  endtask

  task automatic slave_idle();
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; bresp = 0; rresp = 0; rdata = 0;
  endtask

  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [63:0] wd, input logic [4:0] rd,
                         input logic chk_lat);
    int nb, off, aw_n, w_n, ar_n, first_rsp, cyc;
    logic mis, err, b_done, r_done, fin;
    logic [63:0] low, field, exp_rdata, wmask, exp_lane;
    logic [7:0]  exp_strb;
    nb  = 1 << size;
    off = int'(addr[2:0]);
    mis = (addr % nb) != 0;
    low = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8*nb)) - 64'd1);
    field = (rdata_v >> (8*off)) & low;
    if (sgn && ((field >> (8*nb-1)) & 64'd1) == 64'd1) field = field | ~low;
    err = mis ? 1'b0 : (we ? (bresp_v != 2'b00) : (rresp_v != 2'b00));
    exp_rdata = (!we && !mis && !err) ? field : 64'd0;
    exp_strb  = 8'(((1 << nb) - 1) << off);
    wmask = 0;
    for (int i = 0; i < 8; i++) if (exp_strb[i]) wmask[i*8 +: 8] = 8'hFF;
    exp_lane = (wd & low) << (8*off);

    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1; req_we = we; req_addr = addr; req_size = size;
    req_signed = sgn; req_wdata = wd; req_rd = rd;
    @(posedge clk);
    aw_n = 0; w_n = 0; ar_n = 0; first_rsp = -1; b_done = 0; r_done = 0; fin = 0; cyc = 0;
    while (!fin && cyc < 80) begin
      @(negedge clk);
      cyc++;
      req_valid = 0;
      if (cyc == abort_cyc) begin
        chk("abort_awvalid", awvalid, 1'b1);
        rst = 1; slave_idle();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("abort_vld", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'd0);
        chk("abort_req_ready", req_ready, 1'b1);
        return;
      end
      if (rsp_valid) begin
        if (first_rsp < 0) first_rsp = cyc;
        chk("rsp_misalign", rsp_misalign, mis);
        chk("rsp_buserr", rsp_buserr, err);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_rd", rsp_rd, we ? 5'd0 : rd);
        chk("rsp_we", rsp_we, !we && !mis && !err);
        chk("resp_busy", {req_ready, busy}, 2'b01);
        last_rdata = rsp_rdata;
        if (hold > 0) begin rsp_ready = 0; hold--; end
        else begin rsp_ready = 1; fin = 1; end
      end
      // B and R only after the address (and data) beats have been taken.
      if (aw_n == 1 && w_n == 1 && !b_done) begin
        if (b_wait > 0) begin b_wait--; bvalid = 0; end
        else begin bvalid = 1; bresp = bresp_v; if (bready) b_done = 1; end
      end else bvalid = 0;
      if (ar_n == 1 && !r_done) begin
        if (r_wait > 0) begin r_wait--; rvalid = 0; end
        else begin rvalid = 1; rresp = rresp_v; rdata = rdata_v; if (rready) r_done = 1; end
      end else rvalid = 0;
      if (awvalid) begin
        if (aw_wait > 0) begin aw_wait--; awready = 0; end
        else begin awready = 1; aw_n++; chk("awaddr", awaddr, addr); end
      end else awready = 0;
      if (wvalid) begin
        if (w_wait > 0) begin w_wait--; wready = 0; end
        else begin
          wready = 1; w_n++;
          chk("wstrb", wstrb, exp_strb);
          chk("wdata_lanes", wdata & wmask, exp_lane);
        end
      end else wready = 0;
      if (arvalid) begin
        if (ar_wait > 0) begin ar_wait--; arready = 0; end
        else begin arready = 1; ar_n++; chk("araddr", araddr, addr); end
      end else arready = 0;
    end
    if (!fin) chk("rsp_timeout", 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 0;
    slave_idle();
    chk("rsp_cleared", {rsp_valid, req_ready}, 2'b01);
    chk("aw_beats", aw_n, (we && !mis) ? 1 : 0);
    chk("w_beats", w_n, (we && !mis) ? 1 : 0);
    chk("ar_beats", ar_n, (!we && !mis) ? 1 : 0);
    if (chk_lat) chk("latency", first_rsp, mis ? 1 : 3);
  endtask

  initial begin
    logic        we, sgn;
    logic [1:0]  sz;
    logic [31:0] a;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'd0);
    chk("rst_rsp", {rsp_valid, rsp_we, rsp_misalign, rsp_buserr}, 4'd0);
    chk("rst_addr", {awaddr, araddr}, 64'd0);
    chk("rst_wdata", wdata, 64'd0);
    chk("rst_wstrb", wstrb, 8'd0);
    rst = 0;

    slave_cfg(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 64'd0, -1);
    run_txn(1, 32'h8000_0008, 2'd3, 0, 64'h1122_3344_5566_7788, 5'd3, 1);

    slave_cfg(3, 0, 0, 0, 0, 0, 2'b00, 2'b00, 64'd0, -1);
    run_txn(1, 32'h8000_0005, 2'd0, 0, 64'h0000_0000_0000_00AB, 5'd0, 0);

    slave_cfg(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 64'h8001_0000_0000_0000, -1);
    run_txn(0, 32'h8000_0006, 2'd1, 1, 64'd0, 5'd9, 1);
    chk("lh_value", last_rdata, 64'hFFFF_FFFF_FFFF_8001);
    slave_cfg(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 64'h8001_0000_0000_0000, -1);
    run_txn(0, 32'h8000_0006, 2'd1, 0, 64'd0, 5'd9, 1);
    chk("lhu_value", last_rdata, 64'h0000_0000_0000_8001);

    slave_cfg(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 64'd0, -1);
    run_txn(0, 32'h8000_0002, 2'd2, 0, 64'd0, 5'd4, 1);

    slave_cfg(0, 0, 0, 0, 4, 5, 2'b00, 2'b10, 64'hDEAD_BEEF_CAFE_F00D, -1);
    run_txn(0, 32'h8000_0010, 2'd3, 0, 64'd0, 5'd12, 0);

    slave_cfg(10, 10, 0, 0, 0, 0, 2'b00, 2'b00, 64'd0, 2);
    run_txn(1, 32'h8000_0020, 2'd2, 0, 64'h0000_0000_1234_5678, 5'd0, 0);
    slave_cfg(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 64'h0000_00F0_0000_0000, -1);
    run_txn(0, 32'h8000_0004, 2'd0, 0, 64'd0, 5'd17, 1);
    chk("lbu_after_rst", last_rdata, 64'h0000_0000_0000_00F0);

    @(negedge clk);
    rv32 = 1; ra32 = 32'h8000_0010; rs32 = 2'd3;
    @(posedge clk);
    @(negedge clk);
    rv32 = 0;
    chk("dw32_sd_misalign", {rsp_valid32, rsp_mis32, rsp_we32, arvalid32, awvalid32}, 5'b11000);
    rr32 = 1;
    @(posedge clk);
    @(negedge clk);
    rr32 = 0;
    chk("dw32_done", {rsp_valid32, req_ready32}, 2'b01);

    for (int k = 0; k < 200; k++) begin
      we  = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      a   = 32'h8000_0000 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      slave_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                {$urandom, $urandom}, -1);
      run_txn(we, a, sz, sgn, {$urandom, $urandom}, 5'($urandom_range(0, 31)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
Parametrised load/store unit bus master that replaces the single-width, fixed-mask LSU in the MEM stage. It accepts one memory request at a time from the pipeline over a valid/ready interface and runs an AXI4-Lite-style transaction. AW and W are handshaken independently, and bresp/rresp are checked. It returns an aligned, sign/zero-extended load result, or a completion, with error and misalignment flags. It adds parametrised data/address width, response back-pressure, misalign trapping and bus-error reporting.

Parameters:
DATA_WIDTH, 64, bus and register data width; legal values 32 or 64.
ADDR_WIDTH, 32, bus address width.
RD_WIDTH, 5, destination register index width.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  pipeline request valid
req_ready  out  1  block idle, can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_WIDTH  byte address
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double
req_signed  in  1  load sign-extend enable
req_wdata  in  DATA_WIDTH  store data, right-aligned
req_rd  in  RD_WIDTH  load destination register
rsp_valid  out  1  completion valid
rsp_ready  in  1  pipeline accepts completion
rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and faults
rsp_rd  out  RD_WIDTH  destination register; 0 for stores
rsp_we  out  1  register write enable = rsp_valid & load & !fault
rsp_misalign  out  1  address not naturally aligned, or size illegal
rsp_buserr  out  1  bresp/rresp was not OKAY
awvalid/awready/awaddr  out/in/out  1/1/ADDR_WIDTH  write-address channel
wvalid/wready/wdata/wstrb  out/in/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8  write-data channel
bvalid/bready/bresp  in/out/in  1/1/2  write-response channel
arvalid/arready/araddr  out/in/out  1/1/ADDR_WIDTH  read-address channel
rvalid/rready/rdata/rresp  in/out/in/in  1/1/DATA_WIDTH/2  read-data channel
busy  out  1  = !req_ready; drives the pipeline stall

Behaviour:
- Reset: state IDLE, req_ready=1. All of the following are 0: AXI valids, bready, rready, rsp_*, addresses, wdata, wstrb.
- Reset mid-transaction: all valids drop at the next edge and the transaction is abandoned. Slaves share rst, so this is legal.
- Request capture: when req_valid&&req_ready, latch all req_* fields.
- Lane offset OFF = addr[log2(DATA_WIDTH/8)-1:0].
- Misalign: addr is not a multiple of 2^size, or size=3 with DATA_WIDTH=32.
- States: IDLE, WRITE, WRESP, RADDR, RDATA, RESP.
- IDLE, on accept:
  - misaligned -> RESP with rsp_misalign=1; no bus activity.
  - store -> WRITE.
  - load -> RADDR.
  - AXI valids assert the cycle after accept, from registers.
- WRITE:
  - awvalid and wvalid are both held high.
  - Flags aw_done/w_done record each handshake independently, in either order or the same cycle.
  - Each valid drops the cycle after its own handshake.
  - When both handshakes are done (including same-cycle completion) -> WRESP.
  - wdata = req_wdata << (OFF*8).
  - wstrb = ((1<<(1<<size))-1) << OFF.
  - awaddr = req_addr, full address, unaligned.
- WRESP: bready=1. On bvalid -> RESP, with rsp_buserr=(bresp!=0).
- RADDR: arvalid=1, araddr=req_addr. On arready -> RDATA.
- RDATA: rready=1. On rvalid, capture data and -> RESP:
  - rdata is shifted right by OFF*8.
  - It is then truncated to 8<<size bits.
  - It is sign-extended if req_signed, otherwise zero-extended.
  - rsp_buserr=(rresp!=0); if set, rsp_rdata=0.
- RESP:
  - rsp_valid=1; all rsp_* fields stay stable until rsp_ready.
  - rsp_valid&&rsp_ready -> IDLE; rsp_* clear.
  - req_ready stays 0 in RESP: the next request is accepted no earlier than the cycle after the response handshake.
- Latency with zero-wait slave and rsp_ready=1:
  - store: accept at t0, AW+W at t1, B at t2, rsp_valid at t3.
  - load: accept at t0, AR at t1, R at t2, rsp_valid at t3.
  - misaligned: rsp_valid at t1.
- AXI rule: a valid never drops before its handshake. Address, data and strobe are stable while their valid is high.
- Only one transaction is ever outstanding, so read/write ordering is trivially preserved.

Decomposition:
- Package lsu_axi_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - AXI resp codes OKAY/EXOKAY/SLVERR/DECERR;
  - the state enum;
  - a function computing the byte count from size.
- Sub-module lsu_lane_align is purely combinational. It takes OFF, size and signed, and produces the store data shift, wstrb, and the load extract/extend. The FSM top instantiates it once.

Test Plan:
- Aligned sd 0x1122334455667788 to 0x80000008, DW=64, zero-wait slave -> wstrb=0xFF, awaddr=0x80000008, rsp_valid at t3, rsp_we=0.
- sb 0xAB to 0x80000005 -> wdata[47:40]=0xAB, wstrb=0x20; W handshake arrives 3 cycles before AW -> one B, completion once both are done.
- lh signed at 0x80000006 with rdata=0x8001_0000_0000_0000 -> rsp_rdata=0xFFFFFFFFFFFF8001, rsp_rd=req_rd, rsp_we=1; same access with lhu -> 0x0000000000008001.
- lw at 0x80000002 -> rsp_misalign=1 at t1, no arvalid ever; DW=32 with size=3 -> misalign.
- Load where the slave returns rresp=2'b10 after 4 wait cycles -> rsp_buserr=1, rsp_rdata=0, rsp_we=0; rsp_ready held low 5 cycles -> response stable, req_ready=0.
- Assert rst while in WRITE with awvalid high -> next cycle all valids 0, req_ready=1; a following lbu completes normally.
